// File: rtl/register_sequencer.sv
`default_nettype none
// ============================================================================
// register_sequencer : fetch/decode/execute control sequencer for a small
//                      accumulator machine (register writes, C-bus, RAM strobes)
// Revision 1.0 - initial release
// ============================================================================
module register_sequencer #(
    parameter int OPW = 6,
    parameter int NWE = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           z_flag,
    input  logic           mem_ready,
    output logic [NWE-1:0] we,
    output logic [2:0]     bus_sel,
    output logic           alu_add,
    output logic           dr_read,
    output logic           ram_read,
    output logic           ram_write,
    output logic           ld_ir,
    output logic           inc_pc,
    output logic           halted,
    output logic           illegal
);

    localparam logic [OPW-1:0] c_OP_NOP  = OPW'(6'h00);
    localparam logic [OPW-1:0] c_OP_MOV  = OPW'(6'h02);
    localparam logic [OPW-1:0] c_OP_ADD  = OPW'(6'h03);
    localparam logic [OPW-1:0] c_OP_LDM  = OPW'(6'h04);
    localparam logic [OPW-1:0] c_OP_STM  = OPW'(6'h05);
    localparam logic [OPW-1:0] c_OP_JMP  = OPW'(6'h06);
    localparam logic [OPW-1:0] c_OP_JMPZ = OPW'(6'h07);
    localparam logic [OPW-1:0] c_OP_HALT = OPW'(6'h3F);

    localparam int c_WE_AR = 0;
    localparam int c_WE_PC = 1;
    localparam int c_WE_DR = 2;
    localparam int c_WE_AC = 3;

    localparam logic [2:0] c_BUS_PC  = 3'd1;
    localparam logic [2:0] c_BUS_DR  = 3'd2;
    localparam logic [2:0] c_BUS_AC  = 3'd3;
    localparam logic [2:0] c_BUS_R   = 3'd4;
    localparam logic [2:0] c_BUS_ALU = 3'd5;

    typedef enum logic [2:0] {
        S_F1   = 3'd0,
        S_F2   = 3'd1,
        S_F3   = 3'd2,
        S_DEC  = 3'd3,
        S_X1   = 3'd4,
        S_X2   = 3'd5,
        S_X3   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    // Which three-state execute flavour is running; latched in X1 because the
    // opcode is no longer trusted after that state.
    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_LDM  = 2'd1,
        K_STM  = 2'd2,
        K_JMP  = 2'd3
    } kind_t;

    state_t      r_state;
    state_t      w_next;
    kind_t       r_kind;
    kind_t       w_kind_next;

    logic [4:0]  w_we;
    logic [2:0]  w_bus;
    logic        w_alu;
    logic        w_drr;
    logic        w_rr;
    logic        w_rw;
    logic        w_ldir;
    logic        w_inc;
    logic        w_halt;
    logic        w_ill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_F1;
            r_kind  <= K_NONE;
        end else begin
            r_state <= w_next;
            r_kind  <= w_kind_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_kind_next = r_kind;
        w_we        = 5'b0;
        w_bus       = 3'd0;
        w_alu       = 1'b0;
        w_drr       = 1'b0;
        w_rr        = 1'b0;
        w_rw        = 1'b0;
        w_ldir      = 1'b0;
        w_inc       = 1'b0;
        w_halt      = 1'b0;
        w_ill       = 1'b0;

        case (r_state)
            S_F1: begin
                w_bus          = c_BUS_PC;
                w_we[c_WE_AR]  = 1'b1;
                w_next         = S_F2;
            end
            S_F2: begin
                w_rr = 1'b1;
                if (mem_ready) begin
                    w_drr         = 1'b1;
                    w_we[c_WE_DR] = 1'b1;
                    w_next        = S_F3;
                end
            end
            S_F3: begin
                w_ldir = 1'b1;
                w_inc  = 1'b1;
                w_next = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    c_OP_NOP:  w_next = S_F1;
                    c_OP_MOV, c_OP_ADD, c_OP_LDM,
                    c_OP_STM, c_OP_JMP, c_OP_JMPZ:
                               w_next = S_X1;
                    c_OP_HALT: w_next = S_HALT;
                    default: begin
                        w_ill  = 1'b1;
                        w_next = S_F1;
                    end
                endcase
            end
            S_X1: begin
                w_next      = S_F1;
                w_kind_next = K_NONE;
                case (opcode)
                    c_OP_MOV: begin
                        w_bus         = c_BUS_R;
                        w_we[c_WE_AC] = 1'b1;
                    end
                    c_OP_ADD: begin
                        w_bus         = c_BUS_ALU;
                        w_alu         = 1'b1;
                        w_we[c_WE_AC] = 1'b1;
                    end
                    c_OP_LDM: begin
                        w_bus         = c_BUS_PC;
                        w_we[c_WE_AR] = 1'b1;
                        w_kind_next   = K_LDM;
                        w_next        = S_X2;
                    end
                    c_OP_STM: begin
                        w_bus         = c_BUS_R;
                        w_we[c_WE_AR] = 1'b1;
                        w_kind_next   = K_STM;
                        w_next        = S_X2;
                    end
                    c_OP_JMP: begin
                        w_bus         = c_BUS_PC;
                        w_we[c_WE_AR] = 1'b1;
                        w_kind_next   = K_JMP;
                        w_next        = S_X2;
                    end
                    c_OP_JMPZ: begin
                        if (z_flag) begin
                            w_bus         = c_BUS_PC;
                            w_we[c_WE_AR] = 1'b1;
                            w_kind_next   = K_JMP;
                            w_next        = S_X2;
                        end else begin
                            w_inc = 1'b1;
                        end
                    end
                    default: w_next = S_F1;
                endcase
            end
            S_X2: begin
                case (r_kind)
                    K_LDM: begin
                        w_rr = 1'b1;
                        if (mem_ready) begin
                            w_drr         = 1'b1;
                            w_we[c_WE_DR] = 1'b1;
                            w_inc         = 1'b1;
                            w_next        = S_X3;
                        end
                    end
                    K_JMP: begin
                        w_rr = 1'b1;
                        if (mem_ready) begin
                            w_drr         = 1'b1;
                            w_we[c_WE_DR] = 1'b1;
                            w_next        = S_X3;
                        end
                    end
                    K_STM: begin
                        w_bus         = c_BUS_AC;
                        w_we[c_WE_DR] = 1'b1;
                        w_next        = S_X3;
                    end
                    default: w_next = S_F1;
                endcase
            end
            S_X3: begin
                case (r_kind)
                    K_LDM: begin
                        w_bus         = c_BUS_DR;
                        w_we[c_WE_AC] = 1'b1;
                        w_next        = S_F1;
                    end
                    K_JMP: begin
                        w_bus         = c_BUS_DR;
                        w_we[c_WE_PC] = 1'b1;
                        w_next        = S_F1;
                    end
                    K_STM: begin
                        w_rw = 1'b1;
                        if (mem_ready) begin
                            w_next = S_F1;
                        end
                    end
                    default: w_next = S_F1;
                endcase
            end
            S_HALT: begin
                w_halt = 1'b1;
            end
            default: w_next = S_F1;
        endcase
    end

    // Outputs are gated by rst_n directly so an asserted reset kills any strobe
    // within the same cycle, independent of the clock.
    assign bus_sel   = rst_n ? w_bus : 3'd0;
    assign alu_add   = w_alu  & rst_n;
    assign dr_read   = w_drr  & rst_n;
    assign ram_read  = w_rr   & rst_n;
    assign ram_write = w_rw   & rst_n;
    assign ld_ir     = w_ldir & rst_n;
    assign inc_pc    = w_inc  & rst_n;
    assign halted    = w_halt & rst_n;
    assign illegal   = w_ill  & rst_n;

    for (genvar gi = 0; gi < NWE; gi++) begin : g_we
        if (gi < 5) begin : g_used
            assign we[gi] = w_we[gi] & rst_n;
        end else begin : g_unused
            assign we[gi] = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_sequencer.sv
`default_nettype none
// ============================================================================
// tb_register_sequencer : directed and randomized bench with a step-queue model
// Revision 1.0 - initial release
// ============================================================================
module tb_register_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       z_flag = 1'b0;
    logic       mem_ready = 1'b1;
    logic [4:0] we;
    logic [2:0] bus_sel;
    logic       alu_add, dr_read, ram_read, ram_write, ld_ir, inc_pc, halted, illegal;

    int err = 0;
    int chk = 0;
    int ncyc = 0;

    always #5 clk = ~clk;

    register_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .z_flag    (z_flag),
        .mem_ready (mem_ready),
        .we        (we),
        .bus_sel   (bus_sel),
        .alu_add   (alu_add),
        .dr_read   (dr_read),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ld_ir     (ld_ir),
        .inc_pc    (inc_pc),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Output vector: {illegal,halted,inc_pc,ld_ir,ram_write,ram_read,dr_read,alu_add,bus_sel[2:0],we[4:0]}
    localparam logic [15:0] O_WE0 = 16'h0001;
    localparam logic [15:0] O_WE1 = 16'h0002;
    localparam logic [15:0] O_WE2 = 16'h0004;
    localparam logic [15:0] O_WE3 = 16'h0008;
    localparam logic [15:0] B1    = 16'h0020;
    localparam logic [15:0] B2    = 16'h0040;
    localparam logic [15:0] B3    = 16'h0060;
    localparam logic [15:0] B4    = 16'h0080;
    localparam logic [15:0] B5    = 16'h00A0;
    localparam logic [15:0] O_ALU = 16'h0100;
    localparam logic [15:0] O_DRR = 16'h0200;
    localparam logic [15:0] O_RR  = 16'h0400;
    localparam logic [15:0] O_RW  = 16'h0800;
    localparam logic [15:0] O_LDI = 16'h1000;
    localparam logic [15:0] O_INC = 16'h2000;
    localparam logic [15:0] O_HLT = 16'h4000;
    localparam logic [15:0] O_ILL = 16'h8000;

    localparam logic [15:0] V_F1 = 16'h0021;
    localparam logic [15:0] V_F2 = 16'h0604;
    localparam logic [15:0] V_F3 = 16'h3000;

    function automatic logic [15:0] dut_vec();
        return {illegal, halted, inc_pc, ld_ir, ram_write, ram_read, dr_read, alu_add, bus_sel, we};
    endfunction

    // Model: the instruction is a queue of pending cycles; memory cycles repeat
    // until mem_ready, decode and first-execute cycles expand the queue.
    localparam int K_FIX  = 0;
    localparam int K_MEM  = 1;
    localparam int K_DEC  = 2;
    localparam int K_X1   = 3;
    localparam int K_HALT = 4;

    typedef struct {
        int          kind;
        logic [15:0] base;
        logic [15:0] extra;
    } step_t;

    step_t q[$];

    task automatic push(input int k, input logic [15:0] b, input logic [15:0] e);
        step_t s;
        s.kind  = k;
        s.base  = b;
        s.extra = e;
        q.push_back(s);
    endtask

    task automatic push_fetch();
        push(K_FIX, B1 | O_WE0, 16'h0);
        push(K_MEM, O_RR, O_DRR | O_WE2);
        push(K_FIX, O_LDI | O_INC, 16'h0);
        push(K_DEC, 16'h0, 16'h0);
    endtask

    task automatic push_jump();
        push(K_MEM, O_RR, O_DRR | O_WE2);
        push(K_FIX, B2 | O_WE1, 16'h0);
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        return (op == 6'h00) || (op >= 6'h02 && op <= 6'h07) || (op == 6'h3F);
    endfunction

    function automatic logic [15:0] x1_out(input logic [5:0] op, input logic z);
        case (op)
            6'h02:        return B4 | O_WE3;
            6'h03:        return B5 | O_ALU | O_WE3;
            6'h04, 6'h06: return B1 | O_WE0;
            6'h05:        return B4 | O_WE0;
            6'h07:        return z ? (B1 | O_WE0) : O_INC;
            default:      return 16'h0;
        endcase
    endfunction

    function automatic logic [15:0] model_out();
        if (!rst_n) return 16'h0;
        case (q[0].kind)
            K_FIX:   return q[0].base;
            K_MEM:   return mem_ready ? (q[0].base | q[0].extra) : q[0].base;
            K_DEC:   return is_legal(opcode) ? 16'h0 : O_ILL;
            K_X1:    return x1_out(opcode, z_flag);
            default: return O_HLT;
        endcase
    endfunction

    task automatic model_advance();
        int k;
        if (!rst_n) begin
            q.delete();
            push_fetch();
            return;
        end
        k = q[0].kind;
        case (k)
            K_FIX: q.delete(0);
            K_MEM: if (mem_ready) q.delete(0);
            K_DEC: begin
                q.delete(0);
                if (opcode == 6'h3F) push(K_HALT, 16'h0, 16'h0);
                else if (opcode >= 6'h02 && opcode <= 6'h07) push(K_X1, 16'h0, 16'h0);
            end
            K_X1: begin
                q.delete(0);
                case (opcode)
                    6'h04: begin
                        push(K_MEM, O_RR, O_DRR | O_WE2 | O_INC);
                        push(K_FIX, B2 | O_WE3, 16'h0);
                    end
                    6'h05: begin
                        push(K_FIX, B3 | O_WE2, 16'h0);
                        push(K_MEM, O_RW, 16'h0);
                    end
                    6'h06: push_jump();
                    6'h07: if (z_flag) push_jump();
                    default: ;
                endcase
            end
            default: ;
        endcase
        if (q.size() == 0) push_fetch();
    endtask

    // Compare process: every falling edge, DUT against model plus invariants.
    initial begin
        logic [15:0] exp_v, act_v;
        push_fetch();
        forever begin
            @(negedge clk);
            ncyc++;
            exp_v = model_out();
            act_v = dut_vec();
            chk++;
            if (act_v !== exp_v) begin
                err++;
                $display("FAIL model cycle %0d: dut=%h model=%h (op=%h z=%b rdy=%b rst_n=%b)",
                         ncyc, act_v, exp_v, opcode, z_flag, mem_ready, rst_n);
            end
            chk++;
            if (!$onehot0(we) || (ram_read && ram_write)) begin
                err++;
                $display("FAIL exclusivity cycle %0d: we=%b rr=%b rw=%b, want onehot0 we and not both",
                         ncyc, we, ram_read, ram_write);
            end
            model_advance();
        end
    end

    task automatic lit(input string nm, input logic [15:0] want);
        chk++;
        if (dut_vec() !== want) begin
            err++;
            $display("FAIL %s: got %h want %h", nm, dut_vec(), want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string nm, input logic [15:0] want);
        #1;
        lit(nm, want);
        tick();
    endtask

    task automatic fetch();
        mem_ready = 1'b1;
        cyc("F1", V_F1);
        cyc("F2", V_F2);
        cyc("F3", V_F3);
    endtask

    function automatic logic [5:0] pick_op();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0 || r == 9) return 6'h00;
        if (r <= 6) return 6'(r + 1);
        if (r == 7) return 6'($urandom_range(8, 62));
        return 6'h01;
    endfunction

    initial begin
        #3 lit("reset outputs", 16'h0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            fetch();
            cyc("NOP DEC", 16'h0);
        end

        opcode = 6'h15;
        fetch();
        opcode = 6'h03;
        cyc("ADD DEC", 16'h0);
        cyc("ADD X1", B5 | O_ALU | O_WE3);

        opcode = 6'h04;
        fetch();
        cyc("LDM DEC", 16'h0);
        cyc("LDM X1", B1 | O_WE0);
        mem_ready = 1'b0;
        repeat (3) cyc("LDM X2 wait", O_RR);
        mem_ready = 1'b1;
        cyc("LDM X2 done", O_RR | O_DRR | O_WE2 | O_INC);
        cyc("LDM X3", B2 | O_WE3);

        opcode = 6'h07;
        z_flag = 1'b0;
        fetch();
        cyc("JMPZ DEC", 16'h0);
        cyc("JMPZ not-taken X1", O_INC);
        z_flag = 1'b1;
        fetch();
        cyc("JMPZ DEC", 16'h0);
        cyc("JMPZ taken X1", B1 | O_WE0);
        cyc("JMPZ taken X2", O_RR | O_DRR | O_WE2);
        cyc("JMPZ taken X3", B2 | O_WE1);
        z_flag = 1'b0;

        opcode = 6'h15;
        fetch();
        cyc("illegal DEC", O_ILL);

        opcode = 6'h05;
        fetch();
        cyc("STM DEC", 16'h0);
        cyc("STM X1", B4 | O_WE0);
        cyc("STM X2", B3 | O_WE2);
        mem_ready = 1'b0;
        #1 lit("STM X3 wait", O_RW);
        #1 rst_n = 1'b0;
        #1 lit("STM async reset", 16'h0);
        tick();
        #1 lit("reset held", 16'h0);
        tick();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1 lit("F1 after release", V_F1);

        for (int n = 0; n < 4000; n++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            mem_ready = ($urandom_range(0, 3) != 0);
            z_flag    = 1'($urandom_range(0, 1));
            if (!(q[0].kind == K_DEC || q[0].kind == K_X1)) opcode = pick_op();
        end

        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        opcode = 6'h3F;
        fetch();
        cyc("HALT DEC", 16'h0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            z_flag    = 1'($urandom_range(0, 1));
            opcode    = 6'($urandom_range(0, 63));
            cyc("halted hold", O_HLT);
        end
        #1 rst_n = 1'b0;
        #1 lit("halt cleared by reset", 16'h0);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_sequencer.md
REGISTER_SEQUENCER -- requirements
Module: register_sequencer

Interface
REQ-001 The block SHALL have parameter OPW, default 6, meaning opcode width (equal to the instruction register output width).
REQ-002 The block SHALL have parameter NWE, default 5, meaning the width of the register write-enable vector.
REQ-003 The block SHALL have port clk  input  1  single system clock, all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port opcode  input  OPW  current instruction register contents.
REQ-006 The block SHALL have port z_flag  input  1  accumulator-zero flag from the datapath.
REQ-007 The block SHALL have port mem_ready  input  1  RAM handshake, high when the current read or write completes this cycle.
REQ-008 The block SHALL have port we  output  NWE  one-hot register write enables: bit0 AR, bit1 PC, bit2 DR, bit3 AC, bit4 R.
REQ-009 The block SHALL have port bus_sel  output  3  C-bus source: 0 none, 1 PC, 2 DR, 3 AC, 4 R, 5 ALU.
REQ-010 The block SHALL have port alu_add  output  1  ALU performs add when high, pass-through when low.
REQ-011 The block SHALL have ports dr_read (DR loads from RAM), ram_read, ram_write, ld_ir and inc_pc, each output 1.
REQ-012 The block SHALL have ports halted  output  1  and illegal  output  1  (one-cycle pulse on an undefined opcode).

Function
REQ-013 The state register SHALL hold one of: F1, F2, F3, DEC, X1, X2, X3, HALT. Outputs SHALL be decoded combinationally from state, opcode, z_flag and mem_ready. Any output not listed for a state SHALL be 0.
REQ-014 F1 SHALL drive bus_sel=1 and we[0]=1 (AR<-PC), then go to F2.
REQ-015 F2 SHALL hold ram_read=1 until mem_ready=1. In the mem_ready cycle it SHALL also drive dr_read=1 and we[2]=1, then go to F3. Otherwise it SHALL stay in F2.
REQ-016 F3 SHALL drive ld_ir=1 and inc_pc=1, then go to DEC.
REQ-017 DEC SHALL dispatch on opcode: 0x00 NOP -> F1; 0x02, 0x03, 0x04, 0x05, 0x06, 0x07 -> X1; 0x3F -> HALT.
REQ-018 In DEC, any other opcode SHALL pulse illegal=1 for one cycle and then go to F1, treated as a NOP.
REQ-019 MOV (0x02) SHALL use X1: bus_sel=4, alu_add=0, we[3]=1 (AC<-R), then F1.
REQ-020 ADD (0x03) SHALL use X1: bus_sel=5, alu_add=1, we[3]=1 (AC<-AC+R, 16-bit, carry discarded), then F1.
REQ-021 LDM (0x04) SHALL run three states.
- X1: bus_sel=1, we[0]=1.
- X2: ram_read=1 until mem_ready. In the mem_ready cycle: dr_read=1, we[2]=1, inc_pc=1.
- X3: bus_sel=2, we[3]=1, then F1.
REQ-022 STM (0x05) SHALL run three states.
- X1: bus_sel=4, we[0]=1 (AR<-R).
- X2: bus_sel=3, we[2]=1 (DR<-AC).
- X3: ram_write=1 until mem_ready, then F1.
REQ-023 JMP (0x06) SHALL run three states.
- X1: bus_sel=1, we[0]=1.
- X2: ram_read=1 until mem_ready. In the mem_ready cycle: dr_read=1, we[2]=1.
- X3: bus_sel=2, we[1]=1 (PC<-DR), then F1.
REQ-024 JMPZ (0x07) SHALL sample z_flag in X1. If z_flag=1 it SHALL behave as JMP. If z_flag=0 it SHALL drive inc_pc=1 (skip the operand) with no other outputs and go to F1.
REQ-025 The opcode SHALL be read only in DEC and X1. It SHALL be ignored while the sequence is in F1, F2 or F3.
REQ-026 Zero-wait latency SHALL be 4 cycles for NOP and illegal opcodes, 5 for MOV, ADD and not-taken JMPZ, and 7 for LDM, STM, JMP and taken JMPZ. Each mem_ready=0 cycle SHALL add one cycle.
REQ-027 HALT SHALL drive halted=1 with all other outputs 0, and SHALL remain in HALT until reset.
REQ-028 At most one we bit SHALL be high in any cycle. ram_read and ram_write SHALL never be high together.

Reset
REQ-029 While rst_n=0, the state SHALL be forced to F1 asynchronously and every output SHALL be 0, including we, bus_sel, illegal and halted.
REQ-030 The first rising clk edge with rst_n=1 SHALL evaluate F1 outputs, so the F1 outputs are visible during the first cycle after release.
REQ-031 Reset asserted mid-sequence, including during a wait state, SHALL abandon the sequence with no further we, ram_read or ram_write pulse.

Verification
REQ-032 Reset release, mem_ready=1, opcode=0x00 -> states F1,F2,F3,DEC repeat every 4 cycles; we sequence 0x01, 0x04, 0x00, 0x00; one inc_pc per loop.
REQ-033 opcode=0x03, mem_ready=1 -> in X1: bus_sel=5, alu_add=1, we=0x08 for exactly one cycle; the next cycle is F1.
REQ-034 opcode=0x04 with mem_ready low for 3 cycles in X2 -> ram_read high for 4 cycles; dr_read, we=0x04 and inc_pc only in the 4th cycle; then X3 drives bus_sel=2, we=0x08.
REQ-035 opcode=0x07 with z_flag=0 -> X1 drives only inc_pc=1, the next state is F1, and PC is never written. With z_flag=1 -> X3 drives we=0x02, bus_sel=2.
REQ-036 opcode=0x15 -> illegal high for exactly one cycle in DEC, the next state is F1. opcode=0x3F -> halted=1, which stays high for 20 cycles regardless of inputs and clears when rst_n=0.
REQ-037 rst_n pulled low during the X3 wait of STM -> ram_write drops within the same cycle without a clock edge, and all outputs are 0 until release.
